// File: rtl/pwr_seq_pkg.sv
// Shared types and defaults for the power-up sequencer: state encoding,
// default cycle counts and the counter-width helper.
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_INIT    = 3'd2,
        ST_CAL     = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_RUN     = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    localparam int unsigned STARTUP_CYC_DEF = 50000;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000000;
    localparam int unsigned SETTLE_CYC_DEF  = 4096;

    // A configured length of 0 behaves as a length of 1.
    function automatic int unsigned eff_cyc(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    // Bits needed to count 0 .. max-1 for the largest of the three lengths.
    function automatic int cnt_w(input int unsigned a, input int unsigned b,
                                 input int unsigned c);
        longint unsigned m;
        int w;
        m = eff_cyc(a);
        if (eff_cyc(b) > m) m = eff_cyc(b);
        if (eff_cyc(c) > m) m = eff_cyc(c);
        w = 1;
        while ((64'd1 << w) < m) w++;
        return w;
    endfunction

endpackage

// File: rtl/pwr_up_seq.sv
// Power-up sequencer: STARTUP delay, INIT and CAL handshakes, SETTLE delay, then RUN.
// Define PWR_SEQ_RETRY_EN to allow one handshake retry per pass before faulting.
module pwr_up_seq
    import pwr_seq_pkg::*;
#(
    parameter int unsigned STARTUP_CYC = STARTUP_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       cal_done,
    input  logic       fault_clr,
    output logic       sensor_en,
    output logic       init_start,
    output logic       cal_start,
    output logic       pwr_ok,
    output logic       fault,
    output logic [2:0] seq_state
);

    localparam int CW = cnt_w(STARTUP_CYC, TIMEOUT_CYC, SETTLE_CYC);
    localparam logic [CW-1:0] STARTUP_LAST = CW'(eff_cyc(STARTUP_CYC) - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(eff_cyc(TIMEOUT_CYC) - 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(eff_cyc(SETTLE_CYC) - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          reenter;
    logic          entry;
    logic          done_sel;
    logic          sensor_en_q, init_start_q, cal_start_q, pwr_ok_q, fault_q;
`ifdef PWR_SEQ_RETRY_EN
    logic          retry_q, retry_d;
`endif

    always_comb begin
        state_d  = state_q;
        reenter  = 1'b0;
        done_sel = (state_q == ST_INIT) ? init_done : cal_done;
`ifdef PWR_SEQ_RETRY_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            ST_IDLE:    state_d = ST_STARTUP;
            ST_STARTUP: if (cnt_q == STARTUP_LAST) state_d = ST_INIT;
            ST_INIT, ST_CAL: begin
                // done takes priority over a timeout landing on the same cycle
                if (done_sel) begin
                    state_d = (state_q == ST_INIT) ? ST_CAL : ST_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
`ifdef PWR_SEQ_RETRY_EN
                    if (!retry_q) begin
                        reenter = 1'b1;
                        retry_d = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                    end
`else
                    state_d = ST_FAULT;
`endif
                end
            end
            ST_SETTLE:  if (cnt_q == SETTLE_LAST) state_d = ST_RUN;
            ST_RUN:     state_d = ST_RUN;
            ST_FAULT:   if (fault_clr) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        entry = (state_d != state_q) || reenter;

        if (entry) begin
            cnt_d = '0;
        end else if (state_q inside {ST_STARTUP, ST_INIT, ST_CAL, ST_SETTLE}) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = '0;
        end
`ifdef PWR_SEQ_RETRY_EN
        if (state_d == ST_IDLE) retry_d = 1'b0;
`endif
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sensor_en_q  <= 1'b0;
            init_start_q <= 1'b0;
            cal_start_q  <= 1'b0;
            pwr_ok_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sensor_en_q  <= state_d inside {ST_STARTUP, ST_INIT, ST_CAL, ST_SETTLE, ST_RUN};
            init_start_q <= entry && (state_d == ST_INIT);
            cal_start_q  <= entry && (state_d == ST_CAL);
            pwr_ok_q     <= (state_d == ST_RUN);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

`ifdef PWR_SEQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) retry_q <= 1'b0;
        else     retry_q <= retry_d;
    end
`endif

    assign sensor_en  = sensor_en_q;
    assign init_start = init_start_q;
    assign cal_start  = cal_start_q;
    assign pwr_ok     = pwr_ok_q;
    assign fault      = fault_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_pwr_up_seq.sv
// Directed bench for pwr_up_seq with STARTUP=8, TIMEOUT=20, SETTLE=4.
// Expected values are cycle counts worked out by hand from the state timing.
module tb_pwr_up_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_done = 1'b0;
    logic       cal_done = 1'b0;
    logic       fault_clr = 1'b0;
    logic       sensor_en, init_start, cal_start, pwr_ok, fault;
    logic [2:0] seq_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pwr_up_seq #(
        .STARTUP_CYC(8),
        .TIMEOUT_CYC(20),
        .SETTLE_CYC (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .cal_done  (cal_done),
        .fault_clr (fault_clr),
        .sensor_en (sensor_en),
        .init_start(init_start),
        .cal_start (cal_start),
        .pwr_ok    (pwr_ok),
        .fault     (fault),
        .seq_state (seq_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int st, input int se, input int is,
                              input int cs, input int po, input int f);
        check($sformatf("%s.state", tag),      32'(seq_state),  st);
        check($sformatf("%s.sensor_en", tag),  32'(sensor_en),  se);
        check($sformatf("%s.init_start", tag), 32'(init_start), is);
        check($sformatf("%s.cal_start", tag),  32'(cal_start),  cs);
        check($sformatf("%s.pwr_ok", tag),     32'(pwr_ok),     po);
        check($sformatf("%s.fault", tag),      32'(fault),      f);
    endtask

    // Reset, release, and run to the first INIT cycle (edge 9 after release edge 0).
    task automatic reset_to_init(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check($sformatf("%s.rst_state", tag), 32'(seq_state), 0);
        repeat (9) tick();
        check_outs($sformatf("%s.init_entry", tag), 2, 1, 1, 0, 0, 0);
    endtask

    initial begin
        int bad;

        // Nominal sequence
        rst = 1'b1;
        tick();
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check_outs("nom_e1", 1, 1, 0, 0, 0, 0);
        repeat (7) tick();
        check_outs("nom_e8", 1, 1, 0, 0, 0, 0);
        tick();
        check_outs("nom_e9", 2, 1, 1, 0, 0, 0);
        tick();
        check_outs("nom_e10", 2, 1, 0, 0, 0, 0);
        tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        check_outs("nom_e12", 3, 1, 0, 1, 0, 0);
        tick();
        check("nom_e13.cal_start", 32'(cal_start), 0);
        repeat (3) tick();
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        check_outs("nom_e17", 4, 1, 0, 0, 0, 0);
        repeat (3) tick();
        check_outs("nom_e20", 4, 1, 0, 0, 0, 0);
        tick();
        check_outs("nom_e21", 5, 1, 0, 0, 1, 0);
        fault_clr = 1'b1;
        init_done = 1'b1;
        cal_done  = 1'b1;
        repeat (3) tick();
        fault_clr = 1'b0;
        init_done = 1'b0;
        cal_done  = 1'b0;
        check_outs("run_hold", 5, 1, 0, 0, 1, 0);

        // Init timeout; stray cal_done and fault_clr in INIT must be ignored
        reset_to_init("to");
        cal_done  = 1'b1;
        fault_clr = 1'b1;
        repeat (19) tick();
        check_outs("to_e28", 2, 1, 0, 0, 0, 0);
        cal_done  = 1'b0;
        fault_clr = 1'b0;
        tick();
`ifdef PWR_SEQ_RETRY_EN
        check_outs("retry_e29", 2, 1, 1, 0, 0, 0);
        repeat (19) tick();
        check_outs("retry_e48", 2, 1, 0, 0, 0, 0);
        tick();
`endif
        check_outs("timeout", 6, 0, 0, 0, 0, 1);
        bad = 0;
        repeat (100) begin
            tick();
            if (fault !== 1'b1 || pwr_ok !== 1'b0 || sensor_en !== 1'b0 || seq_state !== 3'd6)
                bad++;
        end
        check("fault_stable_bad_cycles", 32'(bad), 0);

        // Fault recovery
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check_outs("clr", 0, 0, 0, 0, 0, 0);
        repeat (8) tick();
        check_outs("re_e8", 1, 1, 0, 0, 0, 0);
        tick();
        check_outs("re_init", 2, 1, 1, 0, 0, 0);

        // init_done on first INIT cycle, then cal_done on the 20th CAL cycle
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        check_outs("init_first", 3, 1, 0, 1, 0, 0);
        repeat (19) tick();
        check_outs("cal_c19", 3, 1, 0, 0, 0, 0);
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        check_outs("collide", 4, 1, 0, 0, 0, 0);

        // Reset mid-SETTLE with a spurious init_done
        tick();
        rst = 1'b1;
        init_done = 1'b1;
        tick();
        check_outs("rst_settle", 0, 0, 0, 0, 0, 0);
        tick();
        check_outs("rst_hold", 0, 0, 0, 0, 0, 0);
        init_done = 1'b0;
        rst = 1'b0;
        tick();
        check_outs("rst_rel", 1, 1, 0, 0, 0, 0);

        // Reset mid-INIT
        reset_to_init("ri");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outs("rst_init", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
